time_hex_display_seq: RTL and testbench
=======================================

// Module: time_hex_display_seq
// PURPOSE
//  Sequential successor to the combinational elapsed-time display driver. Accepts an IN_WIDTH-bit
//  seconds count through a valid/ready handshake and splits it into s/min/h/days with a shared
//  restoring divider. It drives six active-low 7-seg outputs (HEX5..HEX0). Mode 0 shows HH:MM:SS
//  and mode 1 shows DD.HH.MM. It replaces wide combinational /,% chains on the alarm timer path.
// PARAMETERS
//  IN_WIDTH  32  width of in_seconds; also the cycle count of one divider pass (>=8)
// PORTS
//  clk          in   1         system clock; all logic on its rising edge
//  reset        in   1         asynchronous, active-high; clears all state immediately
//  in_seconds   in   IN_WIDTH  total elapsed seconds (unsigned)
//  in_mode      in   1         0 = HH:MM:SS, 1 = DD.HH.MM; sampled at acceptance
//  in_valid     in   1         request a conversion
//  in_ready     out  1         high only in IDLE; accept = in_valid & in_ready at a rising edge
//  done         out  1         one-cycle pulse when HEX outputs take a new value
//  HEX0..HEX5   out  7 each    active-low segments {g,f,e,d,c,b,a}; HEX0 = rightmost digit
// BEHAVIOUR
//  Reset values:
//   - HEX0..HEX5 = 7'b1000000 (display "000000"); done = 0; in_ready = 1; FSM = IDLE.
//  FSM: IDLE -> DIV_S -> DIV_M -> DIV_H -> DIV_D -> DECODE -> IDLE.
//   - Each DIV_* state lasts exactly IN_WIDTH cycles. DECODE lasts 1 cycle.
//  Passes (quotient feeds the next pass):
//   - DIV_S: q/60 -> remainder = sec
//   - DIV_M: q/60 -> remainder = min
//   - DIV_H: q/24 -> remainder = hr (hours wrap at 24)
//   - DIV_D: q/100 -> remainder = day
//   - All remainders are < 100. Quotients are IN_WIDTH bits with no overflow possible.
//  Latency and outputs:
//   - Accept at edge k. HEX0..5 update and done=1 after edge k+4*IN_WIDTH+1.
//   - in_ready returns to 1 in that same cycle.
//   - All six HEX outputs change together. They hold their value between conversions.
//   - DIV_D always runs, so latency does not depend on mode.
//  Digit split in DECODE (value < 100 -> tens, units; comb compare/subtract, no generic divider):
//   - mode 0: HEX5/4 = hr, HEX3/2 = min, HEX1/0 = sec
//   - mode 1: HEX5/4 = day, HEX3/2 = hr, HEX1/0 = min
//   - Any digit code > 9 decodes to blank 7'b1111111. This is defensive and unreachable.
//  Handshake and boundaries:
//   - in_valid while busy is ignored, not queued. in_seconds and in_mode may change freely
//     once accepted, because they are latched at acceptance.
//   - Back-to-back: if in_valid is high during the done cycle, the next conversion is accepted
//     on that edge.
//   - Reset mid-conversion aborts the conversion. HEX returns to "000000" and done is not
//     pulsed for the aborted request.
//   - in_seconds = 0 displays "000000". in_seconds = all-ones converts correctly.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN:
//   - Defined: HEX5 = 7'b1111111 when its digit is 0. HEX4 = 7'b1111111 when digits 5 and 4
//     are both 0. HEX3..HEX0 are never blanked. Blanking is applied in DECODE, so timing is
//     unchanged.
//   - Undefined: all six digits always show their numeral, including leading zeros.
// STRUCTURE
//  Package time_display_pkg:
//   - FSM state encoding.
//   - Divisor constants DIV_SEC=60, DIV_MIN=60, DIV_HR=24, DIV_DAY=100.
//   - seg7_decode(4-bit) function and the SEG_BLANK / SEG_ZERO constants.
//  Sub-module seq_divider:
//   - One instance, restoring shift-subtract, IN_WIDTH-bit dividend, 7-bit divisor.
//   - Ports start/busy/quotient/remainder. One quotient bit per cycle.
//   - Reused for all four passes; the top FSM selects the divisor per pass.
// TESTING
//  1 reset asserted -> HEX0..5=7'b1000000, in_ready=1, done=0; also checked mid-conversion
//    (HEX back to "000000", no done pulse)
//  2 in_seconds=3661, mode 0 -> "010101":
//    HEX5/3/1=7'b1000000, HEX4/2/0=7'b1111001; done exactly 129 cycles after acceptance
//  3 86399 -> "235959"; then 86400 -> "000000" (24 h wrap)
//  4 90061, mode 1 -> days=01 hr=01 min=01, "010101"; in_seconds=32'hFFFFFFFF:
//    mode 0 -> "062815", mode 1 -> "100628"
//  5 second in_valid pulse while busy -> in_ready=0, request dropped, only one done pulse;
//    in_valid held through done -> next conversion accepted on that edge
//  6 LEADING_ZERO_BLANK_EN defined, 3661 mode 0 -> HEX5=7'b1111111, HEX4=7'b1111001;
//    input 0 -> HEX5=HEX4=7'b1111111, HEX3..0="0000"

Source files
------------

// File: rtl/time_display_pkg.sv
// ----------------------------------------------------------------------------
// time_display_pkg
// Shared definitions for the sequential elapsed-time display driver:
//   - state_t      : top-level conversion FSM encoding
//   - DIV_*        : divisors for the four successive divider passes
//   - SEG_BLANK /
//     SEG_ZERO     : active-low 7-segment patterns {g,f,e,d,c,b,a}
//   - seg7_decode  : BCD digit -> active-low segment pattern
//   - split_tens   : value < 100 -> {tens, units} by compare/subtract
// ----------------------------------------------------------------------------
package time_display_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DIV_S  = 3'd1,
        ST_DIV_M  = 3'd2,
        ST_DIV_H  = 3'd3,
        ST_DIV_D  = 3'd4,
        ST_DECODE = 3'd5
    } state_t;

    localparam int DIVISOR_W = 7;

    localparam logic [DIVISOR_W-1:0] DIV_SEC = 7'd60;
    localparam logic [DIVISOR_W-1:0] DIV_MIN = 7'd60;
    localparam logic [DIVISOR_W-1:0] DIV_HR  = 7'd24;
    localparam logic [DIVISOR_W-1:0] DIV_DAY = 7'd100;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // Active-low segments, bit order {g,f,e,d,c,b,a}. Codes above 9 blank.
    function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Splits a two-digit value into {tens, units} with a priority chain of
    // constant compares; cheaper than a generic divide for such a small range.
    // An out-of-range value yields a units code of 4'hF, which decodes blank.
    function automatic logic [7:0] split_tens(input logic [6:0] value);
        logic [3:0] tens;
        logic [6:0] rest;
        tens = 4'd0;
        rest = value;
        for (int t = 9; t >= 1; t--) begin
            if (tens == 4'd0 && value >= 7'(t * 10)) begin
                tens = 4'(t);
                rest = value - 7'(t * 10);
            end
        end
        return {tens, (rest > 7'd9) ? 4'hF : rest[3:0]};
    endfunction

endpackage

// File: rtl/time_hex_display_seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider
// Restoring shift-subtract divider: IN_WIDTH-bit dividend, 7-bit divisor,
// one quotient bit per cycle. The first step is taken on the start edge
// itself, so a pass started at edge k has its result valid after edge
// k+IN_WIDTH-1 (busy low) and can be chained into the next pass on edge
// k+IN_WIDTH with no idle cycle in between.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   start       : load dividend/divisor and perform the first step
//   dividend    : value to divide (sampled on start)
//   divisor     : divisor, non-zero, < 128 (sampled on start)
//   busy        : steps still outstanding; low means results are valid
//   quotient    : IN_WIDTH-bit quotient
//   remainder   : 7-bit remainder
// ----------------------------------------------------------------------------
module seq_divider
    import time_display_pkg::*;
#(
    parameter int IN_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [IN_WIDTH-1:0]  dividend,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic                 busy,
    output logic [IN_WIDTH-1:0]  quotient,
    output logic [DIVISOR_W-1:0] remainder
);

    localparam int CW = $clog2(IN_WIDTH);

    logic [IN_WIDTH-1:0]  quot_q;
    logic [DIVISOR_W-1:0] rem_q;
    logic [DIVISOR_W-1:0] divisor_q;
    logic [CW-1:0]        count_q;

    logic [IN_WIDTH-1:0]  src_quot;
    logic [DIVISOR_W-1:0] src_rem;
    logic [DIVISOR_W-1:0] cur_divisor;
    logic [DIVISOR_W:0]   trial;
    logic [DIVISOR_W:0]   diff;
    logic                 fits;

    // On start the step operates on the fresh operands instead of the registers.
    assign src_quot    = start ? dividend : quot_q;
    assign src_rem     = start ? '0 : rem_q;
    assign cur_divisor = start ? divisor : divisor_q;

    // Partial remainder stays below the divisor, so one extra bit holds the shift.
    assign trial = {src_rem, src_quot[IN_WIDTH-1]};
    assign fits  = trial >= {1'b0, cur_divisor};
    assign diff  = fits ? (trial - {1'b0, cur_divisor}) : trial;

    assign busy      = count_q != '0;
    assign quotient  = quot_q;
    assign remainder = rem_q;

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quot_q    <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            count_q   <= '0;
        end else if (start || busy) begin
            quot_q <= {src_quot[IN_WIDTH-2:0], fits};
            rem_q  <= diff[DIVISOR_W-1:0];
            if (start) begin
                divisor_q <= divisor;
                count_q   <= CW'(IN_WIDTH - 1);
            end else begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/time_hex_display_seq.sv
// ----------------------------------------------------------------------------
// time_hex_display_seq
// Converts an elapsed-seconds count into six active-low 7-segment digits
// using one shared sequential divider run four times (sec, min, hr, day).
//   mode 0: HH:MM:SS     mode 1: DD.HH.MM
// Accept at edge k; HEX outputs update and done pulses after edge
// k+4*IN_WIDTH+1, independent of mode.
// Configuration macro:
//   LEADING_ZERO_BLANK_EN - blank HEX5 when its digit is 0, and HEX4 when
//                           both HEX5 and HEX4 digits are 0.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   in_seconds   : total elapsed seconds (unsigned, IN_WIDTH bits)
//   in_mode      : display mode, sampled at acceptance
//   in_valid     : conversion request
//   in_ready     : high only while idle; accept = in_valid & in_ready
//   done         : one-cycle pulse when HEX0..HEX5 take a new value
//   HEX0..HEX5   : active-low segments {g,f,e,d,c,b,a}, HEX0 rightmost
// ----------------------------------------------------------------------------
module time_hex_display_seq
    import time_display_pkg::*;
#(
    parameter int IN_WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IN_WIDTH-1:0] in_seconds,
    input  logic                in_mode,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                done,
    output logic [6:0]          HEX0,
    output logic [6:0]          HEX1,
    output logic [6:0]          HEX2,
    output logic [6:0]          HEX3,
    output logic [6:0]          HEX4,
    output logic [6:0]          HEX5
);

    state_t state_q, state_d;

    logic                 mode_q;
    logic [DIVISOR_W-1:0] sec_q, min_q, hr_q;

    logic                 div_start;
    logic [IN_WIDTH-1:0]  div_dividend;
    logic [DIVISOR_W-1:0] div_divisor;
    logic                 div_busy;
    logic [IN_WIDTH-1:0]  div_quotient;
    logic [DIVISOR_W-1:0] div_remainder;

    logic [DIVISOR_W-1:0] val_hi, val_mid, val_lo;
    logic [7:0]           bcd_hi, bcd_mid, bcd_lo;
    logic [6:0]           seg5, seg4, seg3, seg2, seg1, seg0;

    seq_divider #(
        .IN_WIDTH (IN_WIDTH)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .busy      (div_busy),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. Each divider pass ends on the cycle busy drops,
    // which makes every DIV_* state exactly IN_WIDTH cycles long.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (in_valid)  state_d = ST_DIV_S;
            ST_DIV_S:  if (!div_busy) state_d = ST_DIV_M;
            ST_DIV_M:  if (!div_busy) state_d = ST_DIV_H;
            ST_DIV_H:  if (!div_busy) state_d = ST_DIV_D;
            ST_DIV_D:  if (!div_busy) state_d = ST_DECODE;
            ST_DECODE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. The next pass is started on the last cycle of the
    // current one, chaining the quotient straight into the divider.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready     = 1'b0;
        div_start    = 1'b0;
        div_dividend = div_quotient;
        div_divisor  = DIV_SEC;
        case (state_q)
            ST_IDLE: begin
                in_ready     = 1'b1;
                div_start    = in_valid;
                div_dividend = in_seconds;
                div_divisor  = DIV_SEC;
            end
            ST_DIV_S: begin
                div_start   = !div_busy;
                div_divisor = DIV_MIN;
            end
            ST_DIV_M: begin
                div_start   = !div_busy;
                div_divisor = DIV_HR;
            end
            ST_DIV_H: begin
                div_start   = !div_busy;
                div_divisor = DIV_DAY;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Digit selection and decode. The day count is read straight from the
    // divider, which holds its remainder through DECODE.
    // ------------------------------------------------------------------
    always_comb begin
        val_hi  = mode_q ? div_remainder : hr_q;
        val_mid = mode_q ? hr_q          : min_q;
        val_lo  = mode_q ? min_q         : sec_q;

        bcd_hi  = split_tens(val_hi);
        bcd_mid = split_tens(val_mid);
        bcd_lo  = split_tens(val_lo);

        seg5 = seg7_decode(bcd_hi[7:4]);
        seg4 = seg7_decode(bcd_hi[3:0]);
        seg3 = seg7_decode(bcd_mid[7:4]);
        seg2 = seg7_decode(bcd_mid[3:0]);
        seg1 = seg7_decode(bcd_lo[7:4]);
        seg0 = seg7_decode(bcd_lo[3:0]);

`ifdef LEADING_ZERO_BLANK_EN
        if (bcd_hi[7:4] == 4'd0) begin
            seg5 = SEG_BLANK;
            if (bcd_hi[3:0] == 4'd0) begin
                seg4 = SEG_BLANK;
            end
        end
`else
        // All six digits always show their numeral.
`endif
    end

    // ------------------------------------------------------------------
    // Datapath registers: captured remainders and the display itself.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= 1'b0;
            sec_q  <= '0;
            min_q  <= '0;
            hr_q   <= '0;
            done   <= 1'b0;
            HEX0   <= SEG_ZERO;
            HEX1   <= SEG_ZERO;
            HEX2   <= SEG_ZERO;
            HEX3   <= SEG_ZERO;
            HEX4   <= SEG_ZERO;
            HEX5   <= SEG_ZERO;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE:   if (in_valid)  mode_q <= in_mode;
                ST_DIV_S:  if (!div_busy) sec_q  <= div_remainder;
                ST_DIV_M:  if (!div_busy) min_q  <= div_remainder;
                ST_DIV_H:  if (!div_busy) hr_q   <= div_remainder;
                ST_DECODE: begin
                    HEX0 <= seg0;
                    HEX1 <= seg1;
                    HEX2 <= seg2;
                    HEX3 <= seg3;
                    HEX4 <= seg4;
                    HEX5 <= seg5;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_time_hex_display_seq.sv
// ----------------------------------------------------------------------------
// tb_time_hex_display_seq
// Scoreboard bench: each accepted request pushes the expected display
// (from an arithmetic reference model) and its acceptance cycle; each done
// pulse pops and compares the display, the latency and in_ready.
// ----------------------------------------------------------------------------
module tb_time_hex_display_seq;

    localparam int W   = 32;
    localparam int LAT = 4 * W + 1;
    localparam logic [41:0] ZEROS = {6{7'b1000000}};

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_seconds;
    logic         in_mode;
    logic         in_valid;
    logic         in_ready;
    logic         done;
    logic [6:0]   HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    typedef struct {
        logic [41:0] hex;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   acc_hist[$];
    int   total    = 0;
    int   bad      = 0;
    int   cyc      = 0;
    int   n_accept = 0;
    int   n_done   = 0;

    always #5 clk = ~clk;

    time_hex_display_seq #(.IN_WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_seconds (in_seconds),
        .in_mode    (in_mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .done       (done),
        .HEX0       (HEX0),
        .HEX1       (HEX1),
        .HEX2       (HEX2),
        .HEX3       (HEX3),
        .HEX4       (HEX4),
        .HEX5       (HEX5)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [41:0] model(input logic [W-1:0] s, input logic m);
        logic [W-1:0] q;
        int sec, mn, hr, dy, hi, mid, lo;
        logic [6:0] h5, h4;
        sec = int'(s % 60);  q = s / 60;
        mn  = int'(q % 60);  q = q / 60;
        hr  = int'(q % 24);  q = q / 24;
        dy  = int'(q % 100);
        hi  = m ? dy : hr;
        mid = m ? hr : mn;
        lo  = m ? mn : sec;
        h5  = seg(hi / 10);
        h4  = seg(hi % 10);
`ifdef LEADING_ZERO_BLANK_EN
        if (hi / 10 == 0) h5 = 7'b1111111;
        if (hi == 0)      h4 = 7'b1111111;
`endif
        return {h5, h4, seg(mid / 10), seg(mid % 10), seg(lo / 10), seg(lo % 10)};
    endfunction

    // Acceptance monitor: pushes expectations, flushed by reset.
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            sb.delete();
        end else if (in_valid && in_ready) begin
            sb.push_back('{hex: model(in_seconds, in_mode), acc_cyc: cyc});
            acc_hist.push_back(cyc);
            n_accept++;
        end
    end

    // Completion monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            n_done++;
            check("done_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("hex", 64'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), 64'(e.hex));
                check("latency", 64'(cyc - e.acc_cyc), 64'(LAT));
                check("ready_at_done", 64'(in_ready), 64'd1);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", 64'(in_ready), 64'd1);
    endtask

    // One-cycle request; inputs scrambled afterwards to prove they are latched.
    task automatic send(input logic [W-1:0] s, input logic m);
        wait_ready();
        in_valid   = 1'b1;
        in_seconds = s;
        in_mode    = m;
        @(negedge clk);
        in_valid   = 1'b0;
        in_seconds = $urandom;
        in_mode    = ~m;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        int a0, d0, n;
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_seconds = '0;
        in_mode    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hex", 64'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), 64'(ZEROS));
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        reset = 1'b0;

        // Basic conversions and boundaries.
        send(32'd3661, 1'b0);
        wait_idle();
        check("3661_hex0", 64'(HEX0), 64'(7'b1111001));
        check("3661_hex3", 64'(HEX3), 64'(7'b1000000));
        send(32'd86399, 1'b0);       wait_idle();
        send(32'd86400, 1'b0);       wait_idle();
        send(32'd90061, 1'b1);       wait_idle();
        send(32'hFFFF_FFFF, 1'b0);   wait_idle();
        send(32'hFFFF_FFFF, 1'b1);   wait_idle();
        send(32'd0, 1'b0);           wait_idle();
        for (int i = 0; i < 4; i++) begin
            send($urandom, 1'($urandom_range(0, 1)));
            wait_idle();
        end

        // Request while busy is dropped.
        a0 = n_accept;
        d0 = n_done;
        send(32'd3661, 1'b0);
        repeat (10) @(negedge clk);
        check("busy_not_ready", 64'(in_ready), 64'd0);
        in_valid   = 1'b1;
        in_seconds = 32'd12345;
        @(negedge clk);
        in_valid = 1'b0;
        wait_idle();
        repeat (LAT + 10) @(negedge clk);
        check("busy_one_accept", 64'(n_accept - a0), 64'd1);
        check("busy_one_done", 64'(n_done - d0), 64'd1);

        // Back-to-back: valid held through done.
        a0 = n_accept;
        wait_ready();
        in_valid   = 1'b1;
        in_seconds = 32'd90061;
        in_mode    = 1'b1;
        @(negedge clk);
        in_seconds = 32'd86399;
        in_mode    = 1'b0;
        n = 0;
        while (n_accept < a0 + 2 && n < 400) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        check("b2b_accepts", 64'(n_accept - a0), 64'd2);
        if (acc_hist.size() >= 2)
            check("b2b_gap", 64'(acc_hist[$] - acc_hist[$-1]), 64'(LAT + 1));
        wait_idle();

        // Reset in the middle of a conversion.
        send(32'd4000000, 1'b1);
        repeat (50) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_hex", 64'({HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}), 64'(ZEROS));
        check("abort_done", 64'(done), 64'd0);
        check("abort_ready", 64'(in_ready), 64'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        d0 = n_done;
        repeat (LAT + 20) @(negedge clk);
        check("abort_no_done", 64'(n_done - d0), 64'd0);
        send(32'd3661, 1'b1);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
